// File: rtl/psum_deskew_collector.sv
// Realigns the diagonally skewed bottom-row partial sums of a systolic array into
// whole rows and buffers them in a small credit-managed FIFO.

module psum_lane_dly #(
  parameter int STAGES = 1,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES-1:0][W-1:0] sr_q;

  // Data only; a stale value can never be pushed because the token chain is reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      sr_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sr_q[s] <= sr_q[s-1];
    end
  end

  assign q_o = sr_q[STAGES-1];
endmodule

module psum_deskew_collector #(
  parameter int NUM   = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NUM*32-1:0] in_sum_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NUM*32-1:0] out_row_o,
  output logic              overflow_o,
  output logic [15:0]       row_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM) + 1;

  logic [NUM-1:0][31:0] aligned;
  logic [NUM-2:0]       tok_q, tok_d;
  logic [IW-1:0]        inflight_q, inflight_d;
  logic [NUM*32-1:0]    mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q;
  logic [15:0]          cnt_q;
  logic                 accept, push, pop;
  logic [31:0]          occupancy;

  // Lane i waits NUM-1-i advances so every lane of a row lines up with the last one.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    if (i == NUM-1) begin : g_pass
      assign aligned[i] = in_sum_i[i*32 +: 32];
    end else begin : g_dly
      psum_lane_dly #(.STAGES(NUM-1-i), .W(32)) u_dly (
        .clk  (clk),
        .en_i (en_i),
        .d_i  (in_sum_i[i*32 +: 32]),
        .q_o  (aligned[i])
      );
    end
  end

  // Rows in flight already own a FIFO slot, so the FIFO cannot overflow.
  assign occupancy   = 32'(count_q) + 32'(inflight_q);
  assign in_ready_o  = occupancy < 32'(DEPTH);
  assign accept      = en_i & in_valid_i & in_ready_o;
  assign push        = en_i & tok_q[NUM-2];
  assign out_valid_o = count_q != '0;
  assign pop         = out_valid_o & out_ready_i;
  assign out_row_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign overflow_o  = ovf_q;
  assign row_cnt_o   = cnt_q;

  always_comb begin
    tok_d = tok_q;
    if (en_i) begin
      tok_d[0] = accept;
      for (int i = 1; i < NUM-1; i++) tok_d[i] = tok_q[i-1];
    end
    inflight_d = inflight_q + IW'(accept) - IW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tok_q      <= tok_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        cnt_q    <= cnt_q + 16'd1;
      end
      if (en_i && in_valid_i && !in_ready_o) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= aligned;
  end
endmodule
